serializar_palavra: RTL and testbench
=====================================

Name: serializar_palavra

Overview:
- Transmit-side serializer: accepts one NUM_BYTES-wide word and emits it as a byte stream, one byte per handshake.
- Byte order is selected per word: little-endian (byte 0 first) or big-endian (most significant byte first).
- Sits between word-oriented datapath logic and byte-oriented links, so software-visible word order is fixed by the sender rather than by a separate byte-swap stage.
- Valid/ready on both sides; sustained throughput of 1 byte/cycle with no bubble between words.

Parameters:
- NUM_BYTES, 4, bytes per input word; word width = 8*NUM_BYTES; legal range 2..16.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- entrada  input  8*NUM_BYTES  word to serialize; byte k = entrada[8k+7:8k].
- entrada_valida  input  1  entrada and ordem_big are valid.
- entrada_pronta  output  1  block can accept a word this cycle.
- ordem_big  input  1  0 = byte 0 first; 1 = byte NUM_BYTES-1 first; sampled with the word.
- saida  output  8  current byte.
- saida_valida  output  1  saida holds a valid byte.
- saida_pronta  input  1  downstream accepts the byte.
- saida_ultimo  output  1  saida is the final byte of the word.

Behaviour:
- Reset (rst_n low at a clk edge): state OCIOSO, saida=0, saida_valida=0, saida_ultimo=0, counter=0, holding register cleared. entrada_pronta is forced 0 while rst_n is low.
- Any partially sent word is discarded on reset. No further bytes of it appear.
- FSM has two states:
  - OCIOSO: saida_valida=0; entrada_pronta=1.
  - ENVIANDO: saida_valida=1.
- Word acceptance:
  - A word is accepted when entrada_valida && entrada_pronta.
  - The word and ordem_big are captured, the counter is set to 0, and the state becomes ENVIANDO.
  - The first byte appears on saida the next cycle (latency 1).
- Byte transfer:
  - A byte transfers when saida_valida && saida_pronta.
  - saida, saida_valida and saida_ultimo are registered and remain stable until the transfer occurs.
  - On each transfer the counter increments and the next byte is presented the following cycle.
- Byte selection at count c:
  - ordem_big=0: byte c.
  - ordem_big=1: byte NUM_BYTES-1-c.
- saida_ultimo=1 exactly when c = NUM_BYTES-1 and saida_valida=1.
- entrada_pronta = (state==OCIOSO) || (saida_valida && saida_pronta && saida_ultimo). This is combinational from saida_pronta.
- Last byte transferring, same cycle:
  - If a new word is accepted, the next cycle presents byte 0 of the new word. State stays ENVIANDO and the counter returns to 0. No idle cycle.
  - If no new word is accepted, the next cycle is OCIOSO with saida_valida=0 and saida_ultimo=0.
- Counter width is clog2(NUM_BYTES). It never exceeds NUM_BYTES-1 and wraps only through the reload path.
- saida_pronta held low indefinitely: hold all outputs. No loss, no duplication.
- entrada and ordem_big are ignored when entrada_pronta=0.
- Changing ordem_big mid-word has no effect until the next acceptance.
- Invariant: a big-endian serialization of W equals the little-endian serialization of the byte-reversed W.

Decomposition:
- Shared package holds:
  - byte width constant LARGURA_BYTE=8;
  - state encoding constants OCIOSO and ENVIANDO;
  - a byte-index function that maps count and order to a source byte index, reused by the matching deserializer.
- Single module; no sub-module is warranted.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with entrada_valida=1 → saida_valida=0, saida_ultimo=0, entrada_pronta=0, saida=0. Release → entrada_pronta=1.
- Little-endian: entrada=32'h11223344, ordem_big=0, accepted at cycle N, saida_pronta=1 → saida=44,33,22,11 on cycles N+1..N+4. saida_ultimo=1 only with 11. saida_valida=0 at N+5.
- Big-endian: same word with ordem_big=1 → 11,22,33,44. saida_ultimo with 44.
- Back-to-back: 32'hAABBCCDD (ordem_big=0) then 32'h01020304 (ordem_big=1), entrada_valida held high, saida_pronta=1 → DD,CC,BB,AA,01,02,03,04 on 8 consecutive cycles. entrada_pronta=1 only on the cycles of acceptance and of byte AA.
- Backpressure: send 32'hCAFEF00D (ordem_big=0) and drop saida_pronta for 3 cycles while FE is presented → FE held stable with saida_valida=1 and entrada_pronta=0. Resume → FE then CA, with no duplicates or drops.
- Reset mid-word: pulse rst_n low after 0D,F0 are transferred → saida_valida=0 the cycle after the reset edge. Next word 32'h00000001 (ordem_big=0) emits 01,00,00,00 from count 0.

Source files
------------

// File: rtl/serializar_palavra_pkg.sv
// Shared definitions for the word serializer / deserializer pair.
package serializar_palavra_pkg;

  localparam int unsigned LARGURA_BYTE = 8;

  typedef enum logic {
    OCIOSO   = 1'b0,
    ENVIANDO = 1'b1
  } estado_t;

  // Maps a byte count and word order to the source byte index inside the word.
  function automatic int unsigned indice_byte(input int unsigned cont,
                                              input logic        big,
                                              input int unsigned num_bytes);
    return big ? (num_bytes - 1 - cont) : cont;
  endfunction

endpackage

// File: rtl/serializar_palavra_if.sv
// Word-in / byte-out handshake bundle for the serializer.
interface serializar_palavra_if #(
  parameter int unsigned NUM_BYTES = 4
);
  import serializar_palavra_pkg::*;

  logic [LARGURA_BYTE*NUM_BYTES-1:0] entrada;
  logic                              entrada_valida;
  logic                              entrada_pronta;
  logic                              ordem_big;
  logic [LARGURA_BYTE-1:0]           saida;
  logic                              saida_valida;
  logic                              saida_pronta;
  logic                              saida_ultimo;

  // Environment side: supplies words, consumes bytes.
  modport master (
    output entrada, entrada_valida, ordem_big, saida_pronta,
    input  entrada_pronta, saida, saida_valida, saida_ultimo
  );

  // Serializer side: consumes words, supplies bytes.
  modport slave (
    input  entrada, entrada_valida, ordem_big, saida_pronta,
    output entrada_pronta, saida, saida_valida, saida_ultimo
  );

endinterface

// File: rtl/serializar_palavra.sv
// Word-to-byte serializer with per-word selectable byte order.
module serializar_palavra
  import serializar_palavra_pkg::*;
#(
  parameter int unsigned NUM_BYTES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serializar_palavra_if.slave  bus
);

  localparam int unsigned LARGURA = LARGURA_BYTE * NUM_BYTES;
  localparam int unsigned CW      = $clog2(NUM_BYTES);
  localparam logic [CW-1:0] ULTIMO_CONT = CW'(NUM_BYTES - 1);

  estado_t                 r_estado;
  logic [LARGURA-1:0]      r_palavra;
  logic                    r_ordem;
  logic [CW-1:0]           r_cont;
  logic [LARGURA_BYTE-1:0] r_saida;
  logic                    r_valida;
  logic                    r_ultimo;

  logic                    w_transfere;
  logic                    w_pronta;
  logic                    w_aceita;
  logic [CW-1:0]           w_prox_cont;
  int unsigned             w_idx_novo;
  int unsigned             w_idx_prox;
  logic [LARGURA_BYTE-1:0] w_byte_novo;
  logic [LARGURA_BYTE-1:0] w_byte_prox;

  // Handshake decode; ready also opens while the last byte is leaving.
  always_comb begin
    w_transfere = r_valida && bus.saida_pronta;
    w_pronta    = rst_n && ((r_estado == OCIOSO) || (w_transfere && r_ultimo));
    w_aceita    = bus.entrada_valida && w_pronta;
    w_prox_cont = r_cont + 1'b1;
  end

  // Source byte selection for a freshly accepted word and for the next held byte.
  always_comb begin
    w_idx_novo  = indice_byte(32'd0, bus.ordem_big, NUM_BYTES);
    w_idx_prox  = indice_byte(32'(w_prox_cont), r_ordem, NUM_BYTES);
    w_byte_novo = '0;
    w_byte_prox = '0;
    for (int unsigned k = 0; k < NUM_BYTES; k++) begin
      if (k == w_idx_novo) w_byte_novo = bus.entrada[k*LARGURA_BYTE +: LARGURA_BYTE];
      if (k == w_idx_prox) w_byte_prox = r_palavra[k*LARGURA_BYTE +: LARGURA_BYTE];
    end
  end

  // Serializer FSM with registered byte outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_estado  <= OCIOSO;
      r_palavra <= '0;
      r_ordem   <= 1'b0;
      r_cont    <= '0;
      r_saida   <= '0;
      r_valida  <= 1'b0;
      r_ultimo  <= 1'b0;
    end else if (w_aceita) begin
      // Acceptance covers both the idle case and the reload on the last byte,
      // so the counter only returns to zero through this path.
      r_estado  <= ENVIANDO;
      r_palavra <= bus.entrada;
      r_ordem   <= bus.ordem_big;
      r_cont    <= '0;
      r_saida   <= w_byte_novo;
      r_valida  <= 1'b1;
      r_ultimo  <= 1'b0;
    end else if (w_transfere) begin
      if (r_ultimo) begin
        r_estado <= OCIOSO;
        r_valida <= 1'b0;
        r_ultimo <= 1'b0;
      end else begin
        r_cont   <= w_prox_cont;
        r_saida  <= w_byte_prox;
        r_ultimo <= (w_prox_cont == ULTIMO_CONT);
      end
    end
  end

  assign bus.entrada_pronta = w_pronta;
  assign bus.saida          = r_saida;
  assign bus.saida_valida   = r_valida;
  assign bus.saida_ultimo   = r_ultimo;

endmodule

// File: tb/tb_serializar_palavra.sv
// Self-checking bench for serializar_palavra (NUM_BYTES = 4).
module tb_serializar_palavra;

  localparam int unsigned NB = 4;

  logic clk;
  logic rst_n;

  serializar_palavra_if #(.NUM_BYTES(NB)) bus ();

  serializar_palavra #(.NUM_BYTES(NB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_cmp;
  int unsigned n_err;

  typedef struct {
    logic [31:0] word;
    logic        big;
    logic [7:0]  exp [4];
  } vec_t;

  typedef struct {
    logic [7:0] b;
    logic       last;
  } byte_t;

  byte_t q[$];

  task automatic check(input string nome, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nome, got, exp, $time);
    end
  endtask

  // Advance one clock; inputs are changed 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected byte stream of a word: big-endian is little-endian of the reversed word.
  task automatic push_word(input logic [31:0] w, input logic big);
    logic [31:0] v;
    v = w;
    if (big) v = {w[7:0], w[15:8], w[23:16], w[31:24]};
    for (int j = 0; j < int'(NB); j++) begin
      byte_t e;
      e.b    = v[8*j +: 8];
      e.last = (j == int'(NB) - 1);
      q.push_back(e);
    end
  endtask

  // Apply one word at idle and check its four bytes plus the return to idle.
  task automatic send_check(input string nome, input logic [31:0] w, input logic big,
                            input logic [7:0] e0, input logic [7:0] e1,
                            input logic [7:0] e2, input logic [7:0] e3);
    logic [7:0] e [4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    bus.entrada = w; bus.ordem_big = big; bus.entrada_valida = 1'b1; bus.saida_pronta = 1'b1;
    @(negedge clk);
    check({nome, "_pronta_aceite"}, 32'(bus.entrada_pronta), 32'd1);
    tick();
    bus.entrada_valida = 1'b0;
    bus.ordem_big = ~big;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check({nome, "_saida"}, 32'(bus.saida), 32'(e[k]));
      check({nome, "_valida"}, 32'(bus.saida_valida), 32'd1);
      check({nome, "_ultimo"}, 32'(bus.saida_ultimo), (k == 3) ? 32'd1 : 32'd0);
      tick();
    end
    @(negedge clk);
    check({nome, "_ocioso"}, 32'(bus.saida_valida), 32'd0);
    tick();
  endtask

  vec_t vt [5];

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.entrada = 32'h5A5A5A5A;
    bus.entrada_valida = 1'b1;
    bus.ordem_big = 1'b0;
    bus.saida_pronta = 1'b1;

    vt[0] = '{32'h11223344, 1'b0, '{8'h44, 8'h33, 8'h22, 8'h11}};
    vt[1] = '{32'h11223344, 1'b1, '{8'h11, 8'h22, 8'h33, 8'h44}};
    vt[2] = '{32'hAABBCCDD, 1'b0, '{8'hDD, 8'hCC, 8'hBB, 8'hAA}};
    vt[3] = '{32'h01020304, 1'b1, '{8'h01, 8'h02, 8'h03, 8'h04}};
    vt[4] = '{32'hCAFEF00D, 1'b1, '{8'hCA, 8'hFE, 8'hF0, 8'h0D}};

    // Reset held for two cycles with a word offered.
    tick();
    tick();
    @(negedge clk);
    check("rst_valida", 32'(bus.saida_valida), 32'd0);
    check("rst_ultimo", 32'(bus.saida_ultimo), 32'd0);
    check("rst_pronta", 32'(bus.entrada_pronta), 32'd0);
    check("rst_saida", 32'(bus.saida), 32'd0);
    tick();
    rst_n = 1'b1;
    bus.entrada_valida = 1'b0;
    @(negedge clk);
    check("rst_libera_pronta", 32'(bus.entrada_pronta), 32'd1);
    tick();

    // Table of single words at full downstream throughput.
    for (int i = 0; i < 5; i++)
      send_check($sformatf("vec%0d", i), vt[i].word, vt[i].big,
                 vt[i].exp[0], vt[i].exp[1], vt[i].exp[2], vt[i].exp[3]);

    // Back-to-back words, no bubble.
    begin
      logic [7:0] eb [8];
      logic       ep [9];
      eb = '{8'hDD, 8'hCC, 8'hBB, 8'hAA, 8'h01, 8'h02, 8'h03, 8'h04};
      ep = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      bus.entrada = 32'hAABBCCDD; bus.ordem_big = 1'b0; bus.entrada_valida = 1'b1;
      bus.saida_pronta = 1'b1;
      for (int i = 0; i < 9; i++) begin
        @(negedge clk);
        check("b2b_pronta", 32'(bus.entrada_pronta), 32'(ep[i]));
        if (i > 0) begin
          check("b2b_saida", 32'(bus.saida), 32'(eb[i-1]));
          check("b2b_valida", 32'(bus.saida_valida), 32'd1);
          check("b2b_ultimo", 32'(bus.saida_ultimo), (i == 4 || i == 8) ? 32'd1 : 32'd0);
        end
        tick();
        if (i == 0) begin bus.entrada = 32'h01020304; bus.ordem_big = 1'b1; end
        if (i == 4) bus.entrada_valida = 1'b0;
      end
      @(negedge clk);
      check("b2b_ocioso", 32'(bus.saida_valida), 32'd0);
      tick();
    end

    // Backpressure while the third byte is presented.
    bus.entrada = 32'hCAFEF00D; bus.ordem_big = 1'b0; bus.entrada_valida = 1'b1;
    bus.saida_pronta = 1'b1;
    tick();
    bus.entrada_valida = 1'b0;
    @(negedge clk); check("bp_b0", 32'(bus.saida), 32'h0D); tick();
    @(negedge clk); check("bp_b1", 32'(bus.saida), 32'hF0); tick();
    bus.saida_pronta = 1'b0;
    bus.entrada_valida = 1'b1; bus.entrada = 32'h99999999;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_hold_saida", 32'(bus.saida), 32'hFE);
      check("bp_hold_valida", 32'(bus.saida_valida), 32'd1);
      check("bp_hold_pronta", 32'(bus.entrada_pronta), 32'd0);
      tick();
    end
    bus.entrada_valida = 1'b0;
    bus.saida_pronta = 1'b1;
    @(negedge clk); check("bp_retoma_b2", 32'(bus.saida), 32'hFE); tick();
    @(negedge clk);
    check("bp_b3", 32'(bus.saida), 32'hCA);
    check("bp_b3_ultimo", 32'(bus.saida_ultimo), 32'd1);
    tick();
    @(negedge clk); check("bp_ocioso", 32'(bus.saida_valida), 32'd0); tick();

    // Reset in the middle of a word.
    bus.entrada = 32'hCAFEF00D; bus.ordem_big = 1'b0; bus.entrada_valida = 1'b1;
    tick();
    bus.entrada_valida = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    check("rstm_pronta_baixo", 32'(bus.entrada_pronta), 32'd0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("rstm_valida", 32'(bus.saida_valida), 32'd0);
    check("rstm_ultimo", 32'(bus.saida_ultimo), 32'd0);
    tick();
    send_check("pos_rst", 32'h00000001, 1'b0, 8'h01, 8'h00, 8'h00, 8'h00);

    // Randomized traffic against a byte-queue reference model.
    q.delete();
    for (int c = 0; c < 3000; c++) begin
      logic exp_pronta;
      logic exp_valida;
      rst_n = ($urandom_range(0, 199) != 0);
      bus.entrada_valida = ($urandom_range(0, 3) != 0);
      bus.entrada = $urandom;
      bus.ordem_big = $urandom_range(0, 1) == 1;
      bus.saida_pronta = ($urandom_range(0, 9) < 7);
      @(negedge clk);
      exp_valida = (q.size() != 0);
      exp_pronta = rst_n && ((q.size() == 0) || (q.size() == 1 && bus.saida_pronta));
      check("rnd_valida", 32'(bus.saida_valida), 32'(exp_valida));
      check("rnd_pronta", 32'(bus.entrada_pronta), 32'(exp_pronta));
      if (exp_valida) begin
        check("rnd_saida", 32'(bus.saida), 32'(q[0].b));
        check("rnd_ultimo", 32'(bus.saida_ultimo), 32'(q[0].last));
      end
      if (!rst_n) q.delete();
      else begin
        if (exp_valida && bus.saida_pronta) void'(q.pop_front());
        if (bus.entrada_valida && exp_pronta) push_word(bus.entrada, bus.ordem_big);
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
